// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state and fetch address width.
package imem_pkg;

   localparam int unsigned IMEM_ADDR_W    = 8;
   localparam logic [7:0]  IMEM_NOP_INSTR = 8'h00;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } imem_state_e;

endpackage : imem_pkg

// File: rtl/instruction_loader_if.sv
// Fetch port toward the core plus the byte-wide valid/ready program load port.
interface instruction_loader_if;
   import imem_pkg::*;

   logic [IMEM_ADDR_W-1:0] ReadAddress;
   logic [7:0]             instruction;
   logic                   cpu_hold;
   logic                   load_start;
   logic                   load_valid;
   logic [7:0]             load_data;
   logic                   load_last;
   logic                   load_ready;
   logic                   load_done;
   logic [8:0]             load_count;
   logic [7:0]             checksum;

   modport master (
      output ReadAddress, load_start, load_valid, load_data, load_last,
      input  instruction, cpu_hold, load_ready, load_done, load_count, checksum
   );

   modport slave (
      input  ReadAddress, load_start, load_valid, load_data, load_last,
      output instruction, cpu_hold, load_ready, load_done, load_count, checksum
   );

endinterface : instruction_loader_if

// File: rtl/instruction_loader_array.sv
// Instruction storage: DEPTH x 8, one synchronous write port, one asynchronous read port, no reset.
module imem_array
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [7:0]  NOP_INSTR = IMEM_NOP_INSTR
) (
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [IMEM_ADDR_W-1:0] wr_addr,
   input  logic [7:0]             wr_data,
   input  logic [IMEM_ADDR_W-1:0] rd_addr,
   output logic [7:0]             rd_data
);

   // Entries hold data XOR NOP_INSTR so an all-zero power-up image reads back as NOP_INSTR.
   logic [7:0] mem_q [DEPTH];
   logic [7:0] raw_rd;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data ^ NOP_INSTR;
      end
   end

   generate
      if (DEPTH < (2 ** IMEM_ADDR_W)) begin : g_partial
         assign raw_rd = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : 8'h00;
      end else begin : g_full
         assign raw_rd = mem_q[rd_addr];
      end
   endgenerate

   assign rd_data = raw_rd ^ NOP_INSTR;

endmodule : imem_array

// File: rtl/instruction_loader.sv
// Instruction store with byte-wide program load port; holds the core off and serves NOP while loading.
// Optional IMEM_CHECKSUM_EN builds a mod-256 checksum of loaded bytes; otherwise checksum reads 8'h00.
module instruction_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [7:0]  NOP_INSTR = IMEM_NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 reset,
   instruction_loader_if.slave  bus
);

   localparam logic [IMEM_ADDR_W-1:0] LAST_ADDR = IMEM_ADDR_W'(DEPTH - 1);

   imem_state_e            state_q, state_d;
   logic [IMEM_ADDR_W-1:0] wptr_q, wptr_d;
   logic [8:0]             count_q, count_d;
   logic                   done_q, done_d;
   logic                   start_req;
   logic                   wr_en;
   logic [7:0]             rd_data;

   imem_array #(
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP_INSTR)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wptr_q),
      .wr_data (bus.load_data),
      .rd_addr (bus.ReadAddress),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      count_d   = count_q;
      done_d    = 1'b0;
      wr_en     = 1'b0;
      start_req = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.load_start) begin
               start_req = 1'b1;
               state_d   = LOAD;
               wptr_d    = '0;
               count_d   = '0;
            end
         end
         LOAD: begin
            if (bus.load_valid) begin
               wr_en   = 1'b1;
               count_d = count_q + 9'd1;
               // The pointer stops at the last entry so it never wraps onto address 0.
               if (bus.load_last || (wptr_q == LAST_ADDR)) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end else begin
                  wptr_d = wptr_q + 1'b1;
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         wptr_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

`ifdef IMEM_CHECKSUM_EN
   logic [7:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (start_req) begin
         checksum_d = '0;
      end else if (wr_en) begin
         checksum_d = checksum_q + bus.load_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = 8'h00;
`endif

   assign bus.cpu_hold    = (state_q == LOAD);
   assign bus.load_ready  = (state_q == LOAD);
   assign bus.load_done   = done_q;
   assign bus.load_count  = count_q;
   assign bus.instruction = (state_q == LOAD) ? NOP_INSTR : rd_data;

endmodule : instruction_loader
